// File: rtl/chess_pkg.sv
// Shared types and constants for the chess move sequencer.
package chess_pkg;

  localparam int unsigned PIECE_W         = 5;
  localparam int unsigned COORD_W         = 3;
  localparam int unsigned SQ_W            = 2 * COORD_W;
  localparam int unsigned CHK_TIMEOUT_DEF = 15;

  // Square contents: type in the top bits, colour, then occupied flag in bit 0
  typedef struct packed {
    logic [2:0] ptype;
    logic       colour;
    logic       occupied;
  } piece_t;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t row;
    coord_t col;
  } sq_t;

  localparam piece_t EMPTY = '0;
  localparam logic   WHITE = 1'b0;
  localparam logic   BLACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_SRC  = 4'd1,
    CAP_SRC = 4'd2,
    HELD    = 4'd3,
    RD_DST  = 4'd4,
    CAP_DST = 4'd5,
    CHECK   = 4'd6,
    WR_DST  = 4'd7,
    WR_SRC  = 4'd8
  } seq_state_t;

  // True when the square holds a piece belonging to the given side
  function automatic logic is_own(input piece_t p, input logic side);
    return p.occupied && (p.colour == side);
  endfunction

endpackage

// File: rtl/chess_move_sequencer_key_edge.sv
// Two-flop synchroniser plus rising-edge detector for one raw key.
module key_edge (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_rise_c
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronise the raw key and keep the previous synchronised level
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise_c = r_sync2 & ~r_prev;

endmodule

// File: rtl/chess_move_sequencer.sv
// Pick-up / put-down sequencer: reads both squares, asks the move checker,
// commits the two board writes and hands the turn to the other side.
module chess_move_sequencer
  import chess_pkg::*;
#(
  parameter int unsigned CHK_TIMEOUT = CHK_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               select_btn,
  input  logic               place_btn,
  input  logic [COORD_W-1:0] cursor_row,
  input  logic [COORD_W-1:0] cursor_col,
  output logic [SQ_W-1:0]    brd_addr,
  input  logic [PIECE_W-1:0] brd_rdata,
  output logic               brd_we,
  output logic [PIECE_W-1:0] brd_wdata,
  output logic               chk_req,
  output logic [SQ_W-1:0]    chk_src,
  output logic [SQ_W-1:0]    chk_dst,
  output logic [PIECE_W-1:0] chk_piece,
  input  logic               chk_ack,
  input  logic               chk_legal,
  output logic               turn,
  output logic               piece_held,
  output logic [PIECE_W-1:0] held_piece,
  output logic               busy,
  output logic               move_done,
  output logic               move_reject
);

  localparam int unsigned CNT_W = $clog2(CHK_TIMEOUT + 1);

  logic w_sel_rise;
  logic w_place_rise;

  key_edge u_sel_edge (
    .clk      (clk),
    .i_rst_n  (reset),
    .i_btn    (select_btn),
    .o_rise_c (w_sel_rise)
  );

  key_edge u_place_edge (
    .clk      (clk),
    .i_rst_n  (reset),
    .i_btn    (place_btn),
    .o_rise_c (w_place_rise)
  );

  seq_state_t       r_state;
  sq_t              r_src;
  sq_t              r_dst;
  logic [CNT_W-1:0] r_cnt;
  sq_t              r_brd_addr;
  logic             r_brd_we;
  piece_t           r_brd_wdata;
  logic             r_chk_req;
  logic             r_turn;
  logic             r_piece_held;
  piece_t           r_held_piece;
  logic             r_busy;
  logic             r_move_done;
  logic             r_move_reject;

  seq_state_t       w_state_nxt;
  sq_t              w_src_nxt;
  sq_t              w_dst_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  sq_t              w_addr_nxt;
  logic             w_we_nxt;
  piece_t           w_wdata_nxt;
  logic             w_req_nxt;
  logic             w_turn_nxt;
  piece_t           w_held_nxt;
  logic             w_done_nxt;
  logic             w_reject_nxt;
  piece_t           w_rdata;
  sq_t              w_cursor;

  assign w_rdata   = piece_t'(brd_rdata);
  assign w_cursor  = '{row: cursor_row, col: cursor_col};
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next-state and next-output decode for the move sequence
  always_comb begin
    w_state_nxt  = r_state;
    w_src_nxt    = r_src;
    w_dst_nxt    = r_dst;
    w_cnt_nxt    = r_cnt;
    w_addr_nxt   = r_brd_addr;
    w_we_nxt     = 1'b0;
    w_wdata_nxt  = r_brd_wdata;
    w_req_nxt    = 1'b0;
    w_turn_nxt   = r_turn;
    w_held_nxt   = r_held_piece;
    w_done_nxt   = 1'b0;
    w_reject_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        // select wins over place here; a lone place edge is meaningless
        if (w_sel_rise) begin
          w_state_nxt = RD_SRC;
          w_src_nxt   = w_cursor;
          w_addr_nxt  = w_cursor;
        end
      end

      RD_SRC: w_state_nxt = CAP_SRC;

      CAP_SRC: begin
        if (is_own(w_rdata, r_turn)) begin
          w_state_nxt = HELD;
          w_held_nxt  = w_rdata;
        end else begin
          w_state_nxt  = IDLE;
          w_held_nxt   = EMPTY;
          w_reject_nxt = 1'b1;
        end
      end

      HELD: begin
        // place wins over a simultaneous select (cancel)
        if (w_place_rise) begin
          w_state_nxt = RD_DST;
          w_dst_nxt   = w_cursor;
          w_addr_nxt  = w_cursor;
        end else if (w_sel_rise) begin
          w_state_nxt = IDLE;
          w_held_nxt  = EMPTY;
        end
      end

      RD_DST: w_state_nxt = CAP_DST;

      CAP_DST: begin
        if ((r_dst == r_src) || is_own(w_rdata, r_turn)) begin
          w_state_nxt  = IDLE;
          w_held_nxt   = EMPTY;
          w_reject_nxt = 1'b1;
        end else begin
          w_state_nxt = CHECK;
          w_req_nxt   = 1'b1;
          w_cnt_nxt   = '0;
        end
      end

      CHECK: begin
        if (chk_ack) begin
          if (chk_legal) begin
            w_state_nxt = WR_DST;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = r_dst;
            w_wdata_nxt = r_held_piece;
          end else begin
            w_state_nxt  = IDLE;
            w_held_nxt   = EMPTY;
            w_reject_nxt = 1'b1;
          end
        end else if (w_cnt_inc == CNT_W'(CHK_TIMEOUT)) begin
          w_state_nxt  = IDLE;
          w_held_nxt   = EMPTY;
          w_reject_nxt = 1'b1;
        end else begin
          w_req_nxt = 1'b1;
          w_cnt_nxt = w_cnt_inc;
        end
      end

      WR_DST: begin
        // destination is already being written; now clear the source square
        w_state_nxt = WR_SRC;
        w_we_nxt    = 1'b1;
        w_addr_nxt  = r_src;
        w_wdata_nxt = EMPTY;
      end

      WR_SRC: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        w_turn_nxt  = ~r_turn;
        w_held_nxt  = EMPTY;
      end

      default: begin
        w_state_nxt = IDLE;
        w_held_nxt  = EMPTY;
      end
    endcase
  end

  // State and registered outputs; the board RAM itself is never reset here
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_src         <= '0;
      r_dst         <= '0;
      r_cnt         <= '0;
      r_brd_addr    <= '0;
      r_brd_we      <= 1'b0;
      r_brd_wdata   <= EMPTY;
      r_chk_req     <= 1'b0;
      r_turn        <= WHITE;
      r_piece_held  <= 1'b0;
      r_held_piece  <= EMPTY;
      r_busy        <= 1'b0;
      r_move_done   <= 1'b0;
      r_move_reject <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_src         <= w_src_nxt;
      r_dst         <= w_dst_nxt;
      r_cnt         <= w_cnt_nxt;
      r_brd_addr    <= w_addr_nxt;
      r_brd_we      <= w_we_nxt;
      r_brd_wdata   <= w_wdata_nxt;
      r_chk_req     <= w_req_nxt;
      r_turn        <= w_turn_nxt;
      r_piece_held  <= w_held_nxt.occupied;
      r_held_piece  <= w_held_nxt;
      r_busy        <= (w_state_nxt != IDLE) && (w_state_nxt != HELD);
      r_move_done   <= w_done_nxt;
      r_move_reject <= w_reject_nxt;
    end
  end

  assign brd_addr    = r_brd_addr;
  assign brd_we      = r_brd_we;
  assign brd_wdata   = r_brd_wdata;
  assign chk_req     = r_chk_req;
  assign chk_src     = r_src;
  assign chk_dst     = r_dst;
  assign chk_piece   = r_held_piece;
  assign turn        = r_turn;
  assign piece_held  = r_piece_held;
  assign held_piece  = r_held_piece;
  assign busy        = r_busy;
  assign move_done   = r_move_done;
  assign move_reject = r_move_reject;

endmodule
